vga_sink: RTL and testbench
===========================

VGA_SINK -- requirements
Module: vga_sink

Interface
REQ-001 Parameters SHALL be: H_TOTAL, default 800, pixel strobes per line.
REQ-002 Parameters SHALL be: V_TOTAL, default 525, lines per frame.
REQ-003 Parameters SHALL be: H_ACT_START, default 144, hcnt of the first active pixel, counted from the hsync falling edge.
REQ-004 Parameters SHALL be: V_ACT_START, default 34, vcnt of the first active line, counted from the vsync falling edge.
REQ-005 Parameters SHALL be: H_ACTIVE 640 and V_ACTIVE 480, the active-window size.
REQ-006 Ports SHALL be: i_clk  in  1  system clock; all logic on the rising edge.
REQ-007 Ports SHALL be: i_rst  in  1  reset, synchronous and active-high.
REQ-008 Ports SHALL be: i_pix_stb  in  1  pixel strobe; inputs are sampled only when it is 1.
REQ-009 Ports SHALL be: i_hs, i_vs  in  1 each  hsync and vsync, both active-low.
REQ-010 Ports SHALL be: i_red [2:0], i_green [2:0], i_blue [1:0]  in  pixel colour.
REQ-011 Ports SHALL be: o_x [9:0], o_y [8:0]  out  recovered pixel coordinate.
REQ-012 Ports SHALL be: o_de  out  1  data enable; o_pix [7:0]  out  packed {R,G,B}.
REQ-013 Ports SHALL be: o_locked  out  1; o_frame_stb  out  1; o_err_stb  out  1; o_err_cnt [7:0]  out.
REQ-014 Ports SHALL be: o_frame_sum [15:0]  out  per-frame pixel checksum.

Function
REQ-015 Sync edge detection SHALL be: registered previous i_hs and i_vs, updated only on i_pix_stb; a falling edge is previous=1 and current=0.
REQ-016 hcnt (10 bit) SHALL be cleared to 0 on an hs falling edge and otherwise increment per strobe, saturating at 1023.
REQ-017 vcnt (10 bit) SHALL be updated only on an hs falling edge: cleared to 0 if vs also shows a falling edge, else incremented, saturating at 1023.
REQ-018 A line-length error SHALL be flagged on an hs falling edge when a previous hs edge has been seen and hcnt != H_TOTAL-1.
REQ-019 A frame-length error SHALL be flagged on a vs falling edge when a previous vs edge has been seen and vcnt != V_TOTAL-1.
REQ-020 The FSM states SHALL be UNLOCKED, ACQUIRE and LOCKED.
REQ-021 UNLOCKED SHALL move to ACQUIRE on a vs falling edge.
REQ-022 ACQUIRE SHALL move to LOCKED on the next vs falling edge when no error occurred.
REQ-023 Any error in ACQUIRE or LOCKED SHALL move the FSM to UNLOCKED.
REQ-024 Errors SHALL be ignored in UNLOCKED.
REQ-025 o_locked SHALL be 1 only in LOCKED.
REQ-026 On an error in ACQUIRE or LOCKED, o_err_stb SHALL pulse for exactly one i_clk.
REQ-027 On the same error, o_err_cnt SHALL increment by 1, saturating at 255.
REQ-028 A line error and a frame error on the same strobe SHALL count as one error.
REQ-029 The active window SHALL be H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE and V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE.
REQ-030 Latency SHALL be one i_clk: the cycle after a strobe in the window with o_locked=1, o_de=1, o_x=hcnt-H_ACT_START, o_y=vcnt-V_ACT_START, o_pix = sampled colour.
REQ-031 In all other cycles o_de, o_x, o_y and o_pix SHALL be 0.
REQ-032 o_frame_stb SHALL pulse for one i_clk, the cycle after each vs falling edge, while the FSM is in LOCKED.

Reset
REQ-033 While i_rst=1, the FSM SHALL go to UNLOCKED and hcnt, vcnt, the edge history and the "edge seen" flags SHALL clear.
REQ-034 While i_rst=1, every output SHALL be 0, including o_err_cnt and o_frame_sum.
REQ-035 Reset asserted mid-frame SHALL take effect on the next i_clk edge, regardless of i_pix_stb.
REQ-036 After reset the block SHALL require two vs falling edges before relocking.

Configuration
REQ-037 With VGA_SINK_CHECKSUM_EN defined, a 16-bit accumulator SHALL add zero-extended o_pix, mod 2^16, for each o_de cycle.
REQ-038 With the macro defined, on each o_frame_stb cycle o_frame_sum SHALL load the accumulator total and the accumulator SHALL clear.
REQ-039 With the macro defined, the accumulator SHALL clear on any transition to UNLOCKED.
REQ-040 Without VGA_SINK_CHECKSUM_EN, o_frame_sum SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-041 Lock: nominal 800x525 stream -> o_locked rises the cycle after the 2nd vs falling edge; 307200 o_de cycles per frame; o_err_cnt=0.
REQ-042 Alignment: strobe at hcnt=144, vcnt=34 -> next clk o_de=1, o_x=0, o_y=0.
REQ-043 Alignment: strobe at hcnt=783, vcnt=513 -> next clk o_x=639, o_y=479.
REQ-044 Short line: one 799-strobe line while locked -> single o_err_stb, o_err_cnt=1, o_locked=0, o_de=0; relock after 2 clean vs edges.
REQ-045 Saturation: 300 consecutive bad lines in ACQUIRE/LOCKED -> o_err_cnt=255, no wrap.
REQ-046 Checksum (macro on): every pixel 0x01 for a full frame -> o_frame_sum=0xB000 at o_frame_stb; macro off -> o_frame_sum=0.
REQ-047 Reset: i_rst=1 mid-frame while locked -> all outputs 0 next clk; no o_frame_stb until 2 vs edges after release.

Source files
------------

// File: rtl/vga_sink.sv
// VGA stream sink: recovers pixel coordinates from hsync/vsync, tracks lock and
// counts timing errors. Define VGA_SINK_CHECKSUM_EN to add the per-frame pixel checksum.
module vga_sink #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int V_ACT_START = 34,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic [7:0]  o_pix,
    output logic        o_locked,
    output logic        o_frame_stb,
    output logic        o_err_stb,
    output logic [7:0]  o_err_cnt,
    output logic [15:0] o_frame_sum
);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] ACQUIRE  = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_BEG  = 10'(H_ACT_START);
    localparam logic [9:0] H_END  = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] V_BEG  = 10'(V_ACT_START);
    localparam logic [9:0] V_END  = 10'(V_ACT_START + V_ACTIVE);

    logic       prev_hs, prev_vs, hs_seen, vs_seen;
    logic [9:0] hcnt, vcnt, h_nxt, v_nxt;
    logic [1:0] state, state_nxt;
    logic       hs_fall, vs_fall, line_err, frame_err, err_hit, frame_hit, in_win;

    always_comb begin
        hs_fall   = i_pix_stb & prev_hs & ~i_hs;
        vs_fall   = i_pix_stb & prev_vs & ~i_vs;
        line_err  = hs_fall & hs_seen & (hcnt != H_LAST);
        frame_err = vs_fall & vs_seen & (vcnt != V_LAST);
        err_hit   = (line_err | frame_err) & (state != UNLOCKED);
        frame_hit = vs_fall & (state == LOCKED) & ~err_hit;

        // Coordinates belonging to the current strobe (the hs-fall strobe is hcnt 0)
        h_nxt = hs_fall ? '0 : ((hcnt == '1) ? hcnt : hcnt + 10'd1);
        v_nxt = vcnt;
        if (hs_fall) begin
            v_nxt = vs_fall ? '0 : ((vcnt == '1) ? vcnt : vcnt + 10'd1);
        end
        in_win = (h_nxt >= H_BEG) && (h_nxt < H_END) && (v_nxt >= V_BEG) && (v_nxt < V_END);

        state_nxt = state;
        case (state)
            UNLOCKED: if (vs_fall) state_nxt = ACQUIRE;
            ACQUIRE:  if (err_hit) state_nxt = UNLOCKED;
                      else if (vs_fall) state_nxt = LOCKED;
            LOCKED:   if (err_hit) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_hs     <= 1'b0;
            prev_vs     <= 1'b0;
            hs_seen     <= 1'b0;
            vs_seen     <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            state       <= UNLOCKED;
            o_err_stb   <= 1'b0;
            o_err_cnt   <= '0;
            o_frame_stb <= 1'b0;
            o_de        <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_pix       <= '0;
        end else begin
            if (i_pix_stb) begin
                prev_hs <= i_hs;
                prev_vs <= i_vs;
                hcnt    <= h_nxt;
                vcnt    <= v_nxt;
                if (hs_fall) hs_seen <= 1'b1;
                if (vs_fall) vs_seen <= 1'b1;
            end
            state       <= state_nxt;
            o_err_stb   <= err_hit;
            if (err_hit && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 8'd1;
            o_frame_stb <= frame_hit;

            o_de  <= 1'b0;
            o_x   <= '0;
            o_y   <= '0;
            o_pix <= '0;
            if (i_pix_stb && in_win && (state == LOCKED)) begin
                o_de  <= 1'b1;
                o_x   <= h_nxt - H_BEG;
                o_y   <= 9'(v_nxt - V_BEG);
                o_pix <= {i_red, i_green, i_blue};
            end
        end
    end

    assign o_locked = (state == LOCKED);

`ifdef VGA_SINK_CHECKSUM_EN
    logic [15:0] acc, acc_total, frame_sum;

    // o_pix is zero outside o_de cycles, so it can be added unconditionally.
    // The total is latched on the same edge that raises o_frame_stb so both are seen together.
    assign acc_total = acc + {8'h00, o_pix};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (frame_hit) begin
            frame_sum <= acc_total;
            acc       <= '0;
        end else if (err_hit) begin
            acc <= '0;
        end else begin
            acc <= acc_total;
        end
    end

    assign o_frame_sum = frame_sum;
`else
    assign o_frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_sink.sv
// Directed bench for vga_sink using a reduced 40x14 timing so full frames stay short.
module tb_vga_sink;

    localparam int H_T = 40, V_T = 14, H_AS = 6, V_AS = 3, H_A = 30, V_A = 10;
    localparam int HSW = 3, VSW = 2;

`ifdef VGA_SINK_CHECKSUM_EN
    localparam logic [15:0] SUM_FF = 16'h2AD4;
    localparam logic [15:0] SUM_01 = 16'h012C;
`else
    localparam logic [15:0] SUM_FF = 16'h0000;
    localparam logic [15:0] SUM_01 = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        i_rst, i_pix_stb, i_hs, i_vs;
    logic [2:0]  i_red, i_green;
    logic [1:0]  i_blue;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_de, o_locked, o_frame_stb, o_err_stb;
    logic [7:0]  o_pix, o_err_cnt;
    logic [15:0] o_frame_sum;

    vga_sink #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACT_START(H_AS), .V_ACT_START(V_AS),
        .H_ACTIVE(H_A), .V_ACTIVE(V_A)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_pix(o_pix), .o_locked(o_locked),
        .o_frame_stb(o_frame_stb), .o_err_stb(o_err_stb), .o_err_cnt(o_err_cnt),
        .o_frame_sum(o_frame_sum)
    );

    always #5 clk = ~clk;

    int de_cnt = 0, fstb_cnt = 0, estb_cnt = 0;
    always @(negedge clk) begin
        if (o_de === 1'b1) de_cnt++;
        if (o_frame_stb === 1'b1) fstb_cnt++;
        if (o_err_stb === 1'b1) estb_cnt++;
    end

    int n_checks = 0, n_fail = 0;
    int gh = 0, gv = V_T - 1, cur_len = H_T;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] pix;
        logic       de;
        logic [9:0] x;
        logic [8:0] y;
    } probe_t;
    probe_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] pix);
        i_pix_stb = 1'b1;
        i_hs = (gh >= HSW);
        i_vs = (gv >= VSW);
        {i_red, i_green, i_blue} = pix;
        @(posedge clk); #1;
        i_pix_stb = 1'b0;
        gh++;
        if (gh == cur_len) begin
            gh = 0;
            cur_len = H_T;
            gv = (gv == V_T - 1) ? 0 : gv + 1;
        end
    endtask

    task automatic goto_pos(input int h, input int v, input logic [7:0] pix);
        while (!(gh == h && gv == v)) strobe(pix);
    endtask

    task automatic idle();
        i_pix_stb = 1'b0;
        i_hs = 1'b0;
        i_vs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic raw_line(input int len);
        for (int h = 0; h < len; h++) begin
            i_pix_stb = 1'b1;
            i_hs = (h >= HSW);
            i_vs = (h != 0);
            {i_red, i_green, i_blue} = 8'h00;
            @(posedge clk); #1;
        end
        i_pix_stb = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, o_x, o_y, o_de, o_pix, o_locked, o_frame_stb, o_err_stb, o_err_cnt, o_frame_sum};
    endfunction

    initial begin
        int snap;
        logic [7:0] exp_pix;

        tbl[0] = '{6, 2, 8'h3C, 1'b0, 10'd0, 9'd0};
        tbl[1] = '{5, 3, 8'hA5, 1'b0, 10'd0, 9'd0};
        tbl[2] = '{6, 3, 8'hA5, 1'b1, 10'd0, 9'd0};
        tbl[3] = '{7, 3, 8'h5A, 1'b1, 10'd1, 9'd0};
        tbl[4] = '{20, 7, 8'hE3, 1'b1, 10'd14, 9'd4};
        tbl[5] = '{35, 7, 8'h1C, 1'b1, 10'd29, 9'd4};
        tbl[6] = '{36, 7, 8'hFF, 1'b0, 10'd0, 9'd0};
        tbl[7] = '{6, 12, 8'h80, 1'b1, 10'd0, 9'd9};
        tbl[8] = '{35, 12, 8'h7F, 1'b1, 10'd29, 9'd9};
        tbl[9] = '{35, 13, 8'hC3, 1'b0, 10'd0, 9'd0};

        i_rst = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
        i_red = '0; i_green = '0; i_blue = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        i_rst = 1'b0;

        // Acquire lock: first vs edge -> ACQUIRE, second -> LOCKED
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("locked_after_edge1", o_locked, 0);
        goto_pos(0, 0, 8'h01);
        check("locked_before_edge2", o_locked, 0);
        strobe(8'h01);
        check("locked_after_edge2", o_locked, 1);
        check("no_fstb_at_lock", o_frame_stb, 0);
        check("err_cnt_clean", o_err_cnt, 0);

        // Full locked frame of 0xFF, then one of 0x01
        snap = de_cnt;
        goto_pos(0, 0, 8'hFF);
        strobe(8'h01);
        check("de_per_frame", de_cnt - snap, H_A * V_A);
        check("fstb_edge3", o_frame_stb, 1);
        check("sum_ff", o_frame_sum, SUM_FF);
        strobe(8'h01);
        check("fstb_one_cycle", o_frame_stb, 0);
        check("sum_hold", o_frame_sum, SUM_FF);
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("sum_01", o_frame_sum, SUM_01);

        // Alignment probes; each followed by a stb=0 cycle with hs/vs driven low
        for (int i = 0; i < 10; i++) begin
            goto_pos(tbl[i].h, tbl[i].v, 8'h01);
            strobe(tbl[i].pix);
            exp_pix = tbl[i].de ? tbl[i].pix : 8'h00;
            check($sformatf("probe%0d_de", i), o_de, tbl[i].de);
            check($sformatf("probe%0d_x", i), o_x, tbl[i].x);
            check($sformatf("probe%0d_y", i), o_y, tbl[i].y);
            check($sformatf("probe%0d_pix", i), o_pix, exp_pix);
            idle();
            check($sformatf("probe%0d_gap_de", i), {o_de, o_pix}, 9'd0);
        end
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("locked_after_probes", o_locked, 1);
        check("err_cnt_after_probes", o_err_cnt, 0);

        // Short line while locked
        snap = estb_cnt;
        goto_pos(0, 5, 8'h01);
        cur_len = H_T - 1;
        goto_pos(0, 6, 8'h01);
        strobe(8'h01);
        check("short_err_stb", o_err_stb, 1);
        check("short_err_cnt", o_err_cnt, 1);
        check("short_unlocked", o_locked, 0);
        strobe(8'h01);
        check("short_err_stb_drop", o_err_stb, 0);
        goto_pos(6, 7, 8'h01);
        strobe(8'h55);
        check("short_no_de", o_de, 0);
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("relock_edgeA", o_locked, 0);
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("relock_edgeB", o_locked, 1);
        check("short_single_pulse", estb_cnt - snap, 1);

        // Reset mid-frame while locked
        goto_pos(20, 7, 8'h01);
        strobe(8'h99);
        check("pre_reset_de", {o_de, o_x, o_y}, {1'b1, 10'd14, 9'd4});
        i_rst = 1'b1;
        idle();
        check("midreset_outputs", all_outs(), 64'd0);
        strobe(8'h01);
        check("midreset_stb_outputs", all_outs(), 64'd0);
        i_rst = 1'b0;
        snap = fstb_cnt;
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("rst_edge1_unlocked", o_locked, 0);
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        check("rst_edge2_locked", o_locked, 1);
        strobe(8'h01);
        check("rst_no_fstb", fstb_cnt - snap, 0);
        goto_pos(0, 0, 8'h01);
        strobe(8'h01);
        strobe(8'h01);
        check("rst_fstb_edge3", fstb_cnt - snap, 1);

        // Error counter: bad lines with vs every line; one error per ACQUIRE attempt
        i_rst = 1'b1;
        idle();
        idle();
        i_rst = 1'b0;
        raw_line(H_T - 2);
        raw_line(H_T - 2);
        raw_line(H_T - 2);
        check("dual_err_counts_once", o_err_cnt, 1);
        for (int n = 0; n < 598; n++) raw_line(H_T - 2);
        check("err_cnt_saturate", o_err_cnt, 255);
        check("sat_never_locked", o_locked, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
